// File: rtl/i2s_tx_fifo.sv
// Stereo-frame FIFO feeding an I2S master: frames are pushed upstream and popped on
// each falling lrclk edge once enough frames have been buffered (FILL -> RUN).
module i2s_tx_fifo #(
  parameter int DSZ       = 16,
  parameter int AW        = 3,
  parameter int START_LVL = 4
) (
  input  logic           i2s_bclk,
  input  logic           reset_n,
  input  logic           i2s_lrclk,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [DSZ-1:0] s_left,
  input  logic [DSZ-1:0] s_right,
  output logic [DSZ-1:0] left_data_out,
  output logic [DSZ-1:0] right_data_out,
  output logic [AW:0]    level,
  output logic           underrun,
  input  logic           underrun_clr
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] START_L = (AW + 1)'(START_LVL);
  localparam logic [AW:0] ZERO_L  = {(AW + 1){1'b0}};
  localparam logic [AW:0] ONE_L   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 lrclk_r;
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [AW:0]          level_r;
  logic [2*DSZ-1:0]     mem_r [DEPTH];
  logic [DSZ-1:0]       left_r;
  logic [DSZ-1:0]       right_r;
  logic                 underrun_r;
  logic                 push_s;
  logic                 pop_evt_s;
  logic                 rd_s;
  logic                 urun_s;

  // A full FIFO refuses pushes even when a pop lands in the same cycle.
  assign s_ready   = (level_r != DEPTH_L);
  assign push_s    = s_valid & s_ready;
  assign pop_evt_s = lrclk_r & ~i2s_lrclk;

  assign left_data_out  = left_r;
  assign right_data_out = right_r;
  assign level          = level_r;
  assign underrun       = underrun_r;

  // Next-state decode plus classification of each pop event as read or underrun.
  always_comb begin
    state_nxt_s = state_r;
    rd_s        = 1'b0;
    urun_s      = 1'b0;
    case (state_r)
      FILL: begin
        if (level_r >= START_L) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FILL;
        end
      end
      RUN: begin
        if (pop_evt_s && (level_r != ZERO_L)) begin
          rd_s = 1'b1;
        end else if (pop_evt_s) begin
          urun_s      = 1'b1;
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = FILL;
      end
    endcase
  end

  // State register and lrclk sampler; lrclk idles high so reset never fakes a pop.
  always_ff @(posedge i2s_bclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= FILL;
      lrclk_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      lrclk_r <= i2s_lrclk;
    end
  end

  // Pointer and level bookkeeping; level is kept separately so full/empty need no extra bit.
  always_ff @(posedge i2s_bclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= ZERO_L;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, rd_s})
        2'b10:   level_r <= level_r + ONE_L;
        2'b01:   level_r <= level_r - ONE_L;
        default: level_r <= level_r;
      endcase
    end
  end

  // Frame storage, left sample in the upper half.
  always_ff @(posedge i2s_bclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {s_left, s_right};
    end
  end

  // Output sample registers: silent while filling or on underrun, held between pops.
  always_ff @(posedge i2s_bclk or negedge reset_n) begin
    if (!reset_n) begin
      left_r  <= {DSZ{1'b0}};
      right_r <= {DSZ{1'b0}};
    end else if (rd_s) begin
      left_r  <= mem_r[rd_ptr_r][2*DSZ-1:DSZ];
      right_r <= mem_r[rd_ptr_r][DSZ-1:0];
    end else if (urun_s || (state_r == FILL)) begin
      left_r  <= {DSZ{1'b0}};
      right_r <= {DSZ{1'b0}};
    end else begin
      left_r  <= left_r;
      right_r <= right_r;
    end
  end

  // Sticky underrun flag; a fresh underrun beats a simultaneous clear.
  always_ff @(posedge i2s_bclk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_r <= 1'b0;
    end else if (urun_s) begin
      underrun_r <= 1'b1;
    end else if (underrun_clr) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Self-checking bench for i2s_tx_fifo: a vector table for the start-up sequence,
// then scoreboard-driven sequences for full, underrun, wrap and async reset cases.
module tb_i2s_tx_fifo;

  localparam int DSZ   = 16;
  localparam int AW    = 3;
  localparam int START = 4;
  localparam int DEPTH = 8;

  logic           i2s_bclk = 1'b0;
  logic           reset_n;
  logic           i2s_lrclk;
  logic           s_valid;
  logic           s_ready;
  logic [DSZ-1:0] s_left;
  logic [DSZ-1:0] s_right;
  logic [DSZ-1:0] left_data_out;
  logic [DSZ-1:0] right_data_out;
  logic [AW:0]    level;
  logic           underrun;
  logic           underrun_clr;

  i2s_tx_fifo #(.DSZ(DSZ), .AW(AW), .START_LVL(START)) dut (
    .i2s_bclk       (i2s_bclk),
    .reset_n        (reset_n),
    .i2s_lrclk      (i2s_lrclk),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_left         (s_left),
    .s_right        (s_right),
    .left_data_out  (left_data_out),
    .right_data_out (right_data_out),
    .level          (level),
    .underrun       (underrun),
    .underrun_clr   (underrun_clr)
  );

  always #5 i2s_bclk = ~i2s_bclk;

  typedef struct {
    bit          v;
    logic [15:0] l;
    logic [15:0] r;
    bit          lr;
    logic [3:0]  lvl;
    bit          rdy;
    logic [15:0] el;
    logic [15:0] er;
    bit          und;
  } vec_t;

  vec_t tbl [10];

  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard model
  logic [31:0] sb[$];
  bit          m_run;
  bit          m_lr;
  bit          m_under;
  logic [15:0] m_l;
  logic [15:0] m_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    sb.delete();
    m_run   = 1'b0;
    m_lr    = 1'b1;
    m_under = 1'b0;
    m_l     = 16'h0000;
    m_r     = 16'h0000;
  endtask

  task automatic do_reset();
    s_valid      = 1'b0;
    s_left       = 16'h0000;
    s_right      = 16'h0000;
    i2s_lrclk    = 1'b1;
    underrun_clr = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(posedge i2s_bclk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_left", 32'(left_data_out), 32'd0);
    chk("rst_right", 32'(right_data_out), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    @(negedge i2s_bclk);
    reset_n = 1'b1;
    model_init();
  endtask

  // One bit-clock cycle: drive, predict from the pre-edge model, compare after the edge.
  task automatic tick(input bit v, input logic [15:0] l, input logic [15:0] r,
                      input bit lr, input bit clr);
    bit          acc;
    bit          pop;
    bit          uev;
    logic [31:0] f;
    s_valid      = v;
    s_left       = l;
    s_right      = r;
    i2s_lrclk    = lr;
    underrun_clr = clr;
    acc  = v && (sb.size() != DEPTH);
    pop  = m_lr && !lr;
    m_lr = lr;
    uev  = 1'b0;
    if (m_run) begin
      if (pop && sb.size() > 0) begin
        f   = sb.pop_front();
        m_l = f[31:16];
        m_r = f[15:0];
      end else if (pop) begin
        m_l   = 16'h0000;
        m_r   = 16'h0000;
        uev   = 1'b1;
        m_run = 1'b0;
      end
    end else begin
      m_l = 16'h0000;
      m_r = 16'h0000;
      if (sb.size() >= START) m_run = 1'b1;
    end
    if (uev) m_under = 1'b1;
    else if (clr) m_under = 1'b0;
    if (acc) sb.push_back({l, r});
    @(posedge i2s_bclk);
    #1;
    chk("level", 32'(level), 32'(sb.size()));
    chk("s_ready", 32'(s_ready), 32'(sb.size() != DEPTH));
    chk("left", 32'(left_data_out), 32'(m_l));
    chk("right", 32'(right_data_out), 32'(m_r));
    chk("underrun", 32'(underrun), 32'(m_under));
  endtask

  task automatic pop_evt(input bit v, input logic [15:0] l, input logic [15:0] r);
    tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick(v, l, r, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h1111, 16'h2222, 1'b1, 4'd1, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 16'h2222, 16'h4444, 1'b1, 4'd2, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[2] = '{1'b1, 16'h3333, 16'h6666, 1'b1, 4'd3, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{1'b1, 16'h4444, 16'h8888, 1'b1, 4'd4, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd4, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 4'd3, 1'b1, 16'h1111, 16'h2222, 1'b0};
    tbl[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 4'd3, 1'b1, 16'h1111, 16'h2222, 1'b0};
    tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd3, 1'b1, 16'h1111, 16'h2222, 1'b0};
    tbl[8] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd3, 1'b1, 16'h1111, 16'h2222, 1'b0};
    tbl[9] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 4'd2, 1'b1, 16'h2222, 16'h4444, 1'b0};

    // start-up: fill four frames, enter RUN, first pops
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s_valid   = tbl[i].v;
      s_left    = tbl[i].l;
      s_right   = tbl[i].r;
      i2s_lrclk = tbl[i].lr;
      @(posedge i2s_bclk);
      #1;
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_left", i), 32'(left_data_out), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_right", i), 32'(right_data_out), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_underrun", i), 32'(underrun), 32'(tbl[i].und));
    end

    // full FIFO: eight pushes, ninth held off, one pop frees a slot
    do_reset();
    for (int n = 1; n <= 8; n++) tick(1'b1, 16'(n * 16'h0101), 16'(n * 16'h1010), 1'b1, 1'b0);
    chk("full_level", 32'(level), 32'd8);
    chk("full_ready", 32'(s_ready), 32'd0);
    for (int k = 0; k < 3; k++) tick(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
    chk("full_hold_level", 32'(level), 32'd8);
    tick(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    chk("after_pop_ready", 32'(s_ready), 32'd1);
    chk("after_pop_left", 32'(left_data_out), 32'h0101);
    tick(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    chk("ninth_accepted", 32'(level), 32'd8);

    // level 1 in RUN: one good pop, then underrun, then clear
    do_reset();
    for (int n = 1; n <= 4; n++) tick(1'b1, 16'(16'h0A00 + n), 16'(16'h0B00 + n), 1'b1, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) pop_evt(1'b0, 16'h0000, 16'h0000);
    chk("lvl1_level", 32'(level), 32'd1);
    pop_evt(1'b0, 16'h0000, 16'h0000);
    chk("lvl1_last_left", 32'(left_data_out), 32'h0A04);
    chk("lvl1_last_right", 32'(right_data_out), 32'h0B04);
    pop_evt(1'b0, 16'h0000, 16'h0000);
    chk("urun_flag", 32'(underrun), 32'd1);
    chk("urun_left", 32'(left_data_out), 32'd0);
    tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    chk("urun_cleared", 32'(underrun), 32'd0);

    // sustained streaming at level 4 across pointer wrap, push on the pop cycle
    do_reset();
    for (int n = 0; n < 4; n++) tick(1'b1, 16'(16'h1000 + n), 16'(16'hF000 - n), 1'b1, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    for (int n = 4; n < 28; n++) begin
      tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      tick(1'b1, 16'(16'h1000 + n), 16'(16'hF000 - n), 1'b0, 1'b0);
      chk("stream_level", 32'(level), 32'd4);
      chk("stream_left", 32'(left_data_out), 32'(16'h1000 + n - 4));
      tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    end

    // asynchronous reset between edges with level 5
    do_reset();
    for (int n = 1; n <= 6; n++) tick(1'b1, 16'(16'h7700 + n), 16'(16'h8800 + n), 1'b1, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    pop_evt(1'b0, 16'h0000, 16'h0000);
    chk("pre_arst_level", 32'(level), 32'd5);
    chk("pre_arst_left", 32'(left_data_out), 32'h7701);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_ready", 32'(s_ready), 32'd1);
    chk("arst_left", 32'(left_data_out), 32'd0);
    chk("arst_right", 32'(right_data_out), 32'd0);
    @(negedge i2s_bclk);
    reset_n = 1'b1;
    model_init();

    // empty FIFO in RUN, push coinciding with a pop, clear in the same cycle loses
    for (int n = 1; n <= 4; n++) tick(1'b1, 16'(16'h3300 + n), 16'(16'h4400 + n), 1'b1, 1'b0);
    tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) pop_evt(1'b0, 16'h0000, 16'h0000);
    chk("empty_level", 32'(level), 32'd0);
    tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick(1'b1, 16'h5A5A, 16'hA5A5, 1'b0, 1'b1);
    chk("coinc_underrun", 32'(underrun), 32'd1);
    chk("coinc_left", 32'(left_data_out), 32'd0);
    chk("coinc_level", 32'(level), 32'd1);
    pop_evt(1'b0, 16'h0000, 16'h0000);
    chk("coinc_fill_no_read", 32'(level), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_fifo.md
I2S_TX_FIFO -- requirements
Module: i2s_tx_fifo

Interface
REQ-001 The block SHALL have parameter DSZ, default 16, giving the channel word width in bits.
REQ-002 The block SHALL have parameter AW, default 3, giving a FIFO depth of 2^AW stereo frames.
REQ-003 The block SHALL have parameter START_LVL, default 4, giving the frame count required to leave FILL; legal range 1..2^AW.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-005 i2s_bclk  input  1  I2S bit clock, the sole clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 i2s_lrclk  input  1  word select driven by the downstream I2S master.
REQ-008 s_valid  input  1  upstream frame valid.
REQ-009 s_ready  output  1  FIFO can accept a frame.
REQ-010 s_left  input  DSZ  upstream left sample.
REQ-011 s_right  input  DSZ  upstream right sample.
REQ-012 left_data_out  output  DSZ  left sample presented to the master's left input.
REQ-013 right_data_out  output  DSZ  right sample presented to the master's right input.
REQ-014 level  output  AW+1  number of frames stored, 0..2^AW.
REQ-015 underrun  output  1  sticky underrun flag.
REQ-016 underrun_clr  input  1  synchronous clear for underrun.

Function
REQ-017 The block SHALL accept a push when s_valid and s_ready are both high on a rising edge, storing {s_left,s_right} at the write pointer.
REQ-018 s_ready SHALL equal (level != 2^AW) combinationally from registered state; a full FIFO SHALL NOT accept a push, even when a pop occurs in the same cycle.
REQ-019 The block SHALL register i2s_lrclk once; a pop event is the cycle where the registered value is 1 and the new sample is 0 (falling lrclk edge, i.e. the left slot begins).
REQ-020 The FSM SHALL have two states, FILL and RUN, and SHALL reset into FILL.
REQ-021 In FILL, pop events SHALL NOT read the FIFO, and both outputs SHALL be driven to zero.
REQ-022 FILL->RUN SHALL occur on the cycle after level >= START_LVL; the first read happens at the next pop event.
REQ-023 In RUN, a pop event with level > 0 SHALL load left_data_out/right_data_out from the read pointer and advance it; outputs are registered and change one cycle after the pop event.
REQ-024 Outputs SHALL hold between pop events.
REQ-025 In RUN, a pop event with level == 0 SHALL set underrun, load zero into both outputs, and return to FILL.
REQ-026 A push and a valid pop in the same cycle SHALL leave level unchanged, and both pointers SHALL advance.
REQ-027 A push into an empty FIFO coinciding with a pop event SHALL be treated as an underrun (no bypass); the pushed frame is stored and level becomes 1.
REQ-028 Pointers SHALL be AW bits and wrap from 2^AW-1 to 0; level SHALL be maintained as a separate AW+1-bit counter.
REQ-029 underrun SHALL stay set until underrun_clr is high on a rising edge; a new underrun in the same cycle as underrun_clr SHALL win (flag stays 1).

Reset
REQ-030 While reset_n is low, the block SHALL force: pointers=0, level=0, state=FILL, outputs=0, underrun=0, lrclk register=1; s_ready is then 1.
REQ-031 Reset asserted mid-operation SHALL discard all stored frames immediately, without waiting for a clock edge.
REQ-032 Memory contents need not be reset.

Verification
REQ-033 Reset, then push 4 frames (L=0x1111*n, R=0x2222*n, n=1..4), then toggle lrclk -> RUN entered; after the first lrclk falling edge the outputs are 0x1111/0x2222 and level=3.
REQ-034 Push 8 frames with no pops -> level=8, s_ready=0; a 9th push held valid is not accepted; after one pop, s_ready=1.
REQ-035 In RUN with level=1, two pop events -> the first outputs the stored frame, the second sets outputs to 0, underrun=1, state=FILL; underrun_clr then yields underrun=0.
REQ-036 Sustained push every frame period with level=4 -> level constant, and the output sequence matches the input order across pointer wrap (>=20 frames).
REQ-037 Assert reset_n low asynchronously between clock edges with level=5 -> level=0, outputs=0, s_ready=1 before the next edge.
REQ-038 Empty FIFO in RUN, with a push coinciding with a pop event -> underrun=1, outputs=0, level=1, state=FILL.
